// File: rtl/ddr4_cmd_responder.sv
// Behavioural DDR4 command responder: decodes ACT/RD/WR/PRE, tracks bank state and tRCD,
// and returns read data through a CL-deep pipeline.
module ddr4_cmd_responder #(
  parameter int unsigned CL   = 3,
  parameter int unsigned TRCD = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cs_n,
  input  logic        ras_n,
  input  logic        cas_n,
  input  logic        we_n,
  input  logic [2:0]  ba,
  input  logic [1:0]  bg,
  input  logic [15:0] addr,
  input  logic [15:0] dq_in,
  output logic [15:0] rd_dq,
  output logic        rd_valid,
  output logic        cmd_err,
  output logic        timing_err,
  output logic [5:0]  open_cnt
);

  typedef enum logic [2:0] {CmdNop, CmdAct, CmdRd, CmdWr, CmdPre, CmdBad} cmd_e;

  localparam int unsigned CntW = 8;

  cmd_e            cmd;
  logic [4:0]      bank;
  logic [31:0]     open_q, open_d;
  logic [15:0]     row_q [32];
  logic [15:0]     cur_row;
  logic            bank_open;
  logic [5:0]      open_cnt_q, open_cnt_d;
  logic [4:0]      last_bank_q;
  logic [CntW-1:0] trcd_cnt_q;
  logic            trcd_hit;
  logic            act_fire, rd_fire, wr_fire;
  logic            cmd_err_q, cmd_err_d, timing_err_q, timing_err_d;
  logic [15:0]     mem [1024];
  logic [9:0]      mem_idx;
  logic [15:0]     mem_rdata;
  logic [CL-1:0]   vld_q;
  logic [15:0]     pdat_q [CL];
  logic            unused_bits;

  assign bank      = {bg, ba};
  assign bank_open = open_q[bank];
  assign cur_row   = row_q[bank];
  assign mem_idx   = {bank, cur_row[2:0], addr[1:0]};
  assign mem_rdata = mem[mem_idx];
  assign trcd_hit  = (bank == last_bank_q) && ((32'(trcd_cnt_q) + 32'd1) < TRCD);
  assign unused_bits = ^{addr[15:10], addr[9:2], cur_row[15:3]};

  always_comb begin
    cmd = CmdNop;
    if (!cs_n) begin
      unique case ({ras_n, cas_n, we_n})
        3'b011:  cmd = CmdAct;
        3'b101:  cmd = CmdRd;
        3'b100:  cmd = CmdWr;
        3'b010:  cmd = CmdPre;
        3'b111:  cmd = CmdNop;
        default: cmd = CmdBad;
      endcase
    end
  end

  always_comb begin
    open_d       = open_q;
    open_cnt_d   = open_cnt_q;
    cmd_err_d    = 1'b0;
    timing_err_d = 1'b0;
    act_fire     = 1'b0;
    rd_fire      = 1'b0;
    wr_fire      = 1'b0;
    unique case (cmd)
      CmdAct: begin
        if (bank_open) begin
          cmd_err_d = 1'b1;
        end else begin
          open_d[bank] = 1'b1;
          open_cnt_d   = open_cnt_q + 6'd1;
          act_fire     = 1'b1;
        end
      end
      CmdPre: begin
        if (bank_open) begin
          open_d[bank] = 1'b0;
          open_cnt_d   = open_cnt_q - 6'd1;
        end
      end
      CmdRd, CmdWr: begin
        if (!bank_open) begin
          cmd_err_d = 1'b1;
        end else begin
          rd_fire      = (cmd == CmdRd);
          wr_fire      = (cmd == CmdWr);
          // Early access still executes; only the flag is raised.
          timing_err_d = trcd_hit;
        end
      end
      CmdBad:  cmd_err_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      open_q       <= '0;
      open_cnt_q   <= '0;
      cmd_err_q    <= 1'b0;
      timing_err_q <= 1'b0;
      last_bank_q  <= '0;
      trcd_cnt_q   <= '1;
      for (int i = 0; i < 32; i++) row_q[i] <= '0;
    end else begin
      open_q       <= open_d;
      open_cnt_q   <= open_cnt_d;
      cmd_err_q    <= cmd_err_d;
      timing_err_q <= timing_err_d;
      if (act_fire) begin
        row_q[bank] <= addr;
        last_bank_q <= bank;
        trcd_cnt_q  <= '0;
      end else if (trcd_cnt_q != '1) begin
        trcd_cnt_q <= trcd_cnt_q + 1'b1;
      end
    end
  end

  // Storage is deliberately left out of reset so data survives a reset pulse.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[mem_idx] <= dq_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < CL; i++) pdat_q[i] <= '0;
    end else begin
      vld_q[0]  <= rd_fire;
      pdat_q[0] <= rd_fire ? mem_rdata : 16'h0000;
      for (int i = 1; i < CL; i++) begin
        vld_q[i]  <= vld_q[i-1];
        pdat_q[i] <= pdat_q[i-1];
      end
    end
  end

  assign rd_valid   = vld_q[CL-1];
  assign rd_dq      = pdat_q[CL-1];
  assign cmd_err    = cmd_err_q;
  assign timing_err = timing_err_q;
  assign open_cnt   = open_cnt_q;

endmodule
